ob_install_ctrl: RTL and testbench

Front-end controller that sits directly upstream of a bid/ask pair of ob_table instances. It buffers incoming order commands in a FIFO and steers each one to the install port of the correct side's table. It holds back installs to a side while that table reports a pending reject, and drains each table's reject path to a downstream response channel.

---
 rtl/ob_pkg.sv | 10 +
 rtl/ob_install_ctrl.sv | 101 ++++++++++
 tb/tb_ob_install_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ob_pkg.sv
// rtl/ob_pkg.sv - shared order-book entry type used by the install controller and its tables
package ob_pkg;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] price;
    logic [15:0] qty;
  } table_t;

endpackage

// File: rtl/ob_install_ctrl.sv
// rtl/ob_install_ctrl.sv - command FIFO steering installs to bid/ask ob_tables
// and round-robin draining of their reject paths to a response channel.
module ob_install_ctrl #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_vld,
  input  logic                 cmd_is_ask,
  input  ob_pkg::table_t       cmd_entry,
  output logic                 cmd_rdy_r,
  output logic                 bid_install_vld,
  output ob_pkg::table_t       bid_install,
  output logic                 ask_install_vld,
  output ob_pkg::table_t       ask_install,
  input  logic                 bid_reject_valid_r,
  input  logic                 ask_reject_valid_r,
  output logic                 bid_reject_pop,
  output logic                 ask_reject_pop,
  output logic                 rsp_reject_vld,
  output logic                 rsp_reject_is_ask,
  input  logic                 rsp_reject_rdy,
  output logic [CNT_W-1:0]     occupancy_r
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic           is_ask;
    ob_pkg::table_t entry;
  } slot_t;

  slot_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             rdy_q, rdy_d;
  logic             rr_q;

  slot_t head;
  logic  empty, blocked, issue, push;
  logic  any_rej, sel_ask, rsp_hs;

  assign head    = mem_q[rd_ptr_q];
  assign empty   = (occ_q == '0);
  assign blocked = head.is_ask ? ask_reject_valid_r : bid_reject_valid_r;
  assign issue   = rst && !empty && !blocked;
  assign push    = cmd_vld && rdy_q;

  // A lone reject wins outright; rr_q only breaks ties when both sides are pending.
  assign any_rej = bid_reject_valid_r || ask_reject_valid_r;
  assign sel_ask = (bid_reject_valid_r && ask_reject_valid_r) ? rr_q : ask_reject_valid_r;
  assign rsp_hs  = rst && any_rej && rsp_reject_rdy;

  assign occ_d = occ_q + CNT_W'(push) - CNT_W'(issue);
  assign rdy_d = (occ_d < CNT_W'(DEPTH));

  assign cmd_rdy_r         = rdy_q;
  assign occupancy_r       = occ_q;
  assign bid_install_vld   = issue && !head.is_ask;
  assign ask_install_vld   = issue && head.is_ask;
  assign bid_install       = rst ? head.entry : '0;
  assign ask_install       = rst ? head.entry : '0;
  assign rsp_reject_vld    = rst && any_rej;
  assign rsp_reject_is_ask = rst && sel_ask;
  assign bid_reject_pop    = rsp_hs && !sel_ask;
  assign ask_reject_pop    = rsp_hs && sel_ask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      rdy_q    <= 1'b0;
      rr_q     <= 1'b0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (issue)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (rsp_hs) rr_q     <= !sel_ask;
      occ_q <= occ_d;
      rdy_q <= rdy_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{is_ask: cmd_is_ask, entry: cmd_entry};
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(push && occ_q == CNT_W'(DEPTH))) else $error("push into full fifo");
      assert (!(issue && empty)) else $error("pop from empty fifo");
      assert (occ_q <= CNT_W'(DEPTH)) else $error("occupancy overflow");
      assert (!(bid_install_vld && ask_install_vld)) else $error("dual install strobe");
    end
  end
`endif

endmodule

// File: tb/tb_ob_install_ctrl.sv
// tb/tb_ob_install_ctrl.sv - directed and randomized bench for ob_install_ctrl
// against a queue-based reference model.
module tb_ob_install_ctrl;
  import ob_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_vld = 1'b0, cmd_is_ask = 1'b0;
  table_t           cmd_entry = '0;
  logic             cmd_rdy_r;
  logic             bid_install_vld, ask_install_vld;
  table_t           bid_install, ask_install;
  logic             bid_rej = 1'b0, ask_rej = 1'b0;
  logic             bid_reject_pop, ask_reject_pop;
  logic             rsp_reject_vld, rsp_reject_is_ask;
  logic             rsp_rdy = 1'b0;
  logic [CNT_W-1:0] occupancy_r;

  ob_install_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_vld(cmd_vld), .cmd_is_ask(cmd_is_ask), .cmd_entry(cmd_entry), .cmd_rdy_r(cmd_rdy_r),
    .bid_install_vld(bid_install_vld), .bid_install(bid_install),
    .ask_install_vld(ask_install_vld), .ask_install(ask_install),
    .bid_reject_valid_r(bid_rej), .ask_reject_valid_r(ask_rej),
    .bid_reject_pop(bid_reject_pop), .ask_reject_pop(ask_reject_pop),
    .rsp_reject_vld(rsp_reject_vld), .rsp_reject_is_ask(rsp_reject_is_ask),
    .rsp_reject_rdy(rsp_rdy), .occupancy_r(occupancy_r)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic   is_ask;
    table_t entry;
  } cmd_t;

  cmd_t q[$];
  logic exp_rdy    = 1'b0;
  logic prefer_ask = 1'b0;
  int   n_cmp = 0, n_bad = 0;
  int   n_bid_inst = 0, n_ask_inst = 0, n_bid_pop = 0, n_ask_pop = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic table_t rnd_entry();
    table_t e;
    e.id    = 8'($urandom);
    e.price = 16'($urandom);
    e.qty   = 16'($urandom);
    return e;
  endfunction

  // Compare every output against the model for the current cycle and report what the model expects to happen at the coming edge.
  task automatic check_now(output logic e_iss, output logic hs, output logic sel);
    logic any;
    e_iss = 1'b0;
    if (q.size() > 0) e_iss = !(q[0].is_ask ? ask_rej : bid_rej);
    chk("cmd_rdy", cmd_rdy_r, exp_rdy);
    chk("occupancy", occupancy_r, q.size());
    chk("bid_install_vld", bid_install_vld, e_iss && !q[0].is_ask);
    chk("ask_install_vld", ask_install_vld, e_iss && q[0].is_ask);
    if (e_iss) begin
      chk("bid_payload", bid_install, q[0].entry);
      chk("ask_payload", ask_install, q[0].entry);
    end
    any = bid_rej || ask_rej;
    sel = (bid_rej && ask_rej) ? prefer_ask : ask_rej;
    hs  = any && rsp_rdy;
    chk("rsp_vld", rsp_reject_vld, any);
    if (any) chk("rsp_is_ask", rsp_reject_is_ask, sel);
    chk("bid_pop", bid_reject_pop, hs && !sel);
    chk("ask_pop", ask_reject_pop, hs && sel);
  endtask

  task automatic cycle();
    logic e_iss, hs, sel;
    #1;
    check_now(e_iss, hs, sel);
    @(posedge clk);
    if (e_iss) begin
      if (q[0].is_ask) n_ask_inst++; else n_bid_inst++;
      void'(q.pop_front());
    end
    if (cmd_vld && exp_rdy) q.push_back({cmd_is_ask, cmd_entry});
    exp_rdy = (q.size() < DEPTH);
    if (hs) begin
      prefer_ask = !sel;
      if (sel) n_ask_pop++; else n_bid_pop++;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic side, input table_t e);
    cmd_vld = 1'b1; cmd_is_ask = side; cmd_entry = e;
    cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bid_vld"}, bid_install_vld, 1'b0);
    chk({tag, "_ask_vld"}, ask_install_vld, 1'b0);
    chk({tag, "_bid_pop"}, bid_reject_pop, 1'b0);
    chk({tag, "_ask_pop"}, ask_reject_pop, 1'b0);
    chk({tag, "_rsp_vld"}, rsp_reject_vld, 1'b0);
    chk({tag, "_occ"}, occupancy_r, 0);
    chk({tag, "_rdy"}, cmd_rdy_r, 1'b0);
  endtask

  // Assert reset away from any clock edge so the outputs must fall without a clock.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    q.delete();
    exp_rdy = 1'b0;
    prefer_ask = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int base_b, base_a;

    // Reset state with both rejects and a command pending at the inputs.
    bid_rej = 1'b1; ask_rej = 1'b1; rsp_rdy = 1'b1; cmd_vld = 1'b1;
    #3 check_reset_outputs("reset");
    @(negedge clk);
    bid_rej = 1'b0; ask_rej = 1'b0; rsp_rdy = 1'b0; cmd_vld = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cycle();

    // Three back-to-back commands with no rejects.
    send(1'b0, rnd_entry());
    send(1'b1, rnd_entry());
    send(1'b0, rnd_entry());
    cmd_vld = 1'b0;
    repeat (4) cycle();
    chk("abc_bid_installs", n_bid_inst, 2);
    chk("abc_ask_installs", n_ask_inst, 1);

    // Fill behind a blocked bid head, then release it.
    bid_rej = 1'b1;
    repeat (DEPTH) send(1'b0, rnd_entry());
    send(1'b0, rnd_entry());
    cmd_vld = 1'b0;
    #1 chk("full_occupancy", occupancy_r, DEPTH);
    chk("full_rdy", cmd_rdy_r, 1'b0);
    cycle();
    bid_rej = 1'b0;
    n_bid_inst = 0;
    repeat (DEPTH) cycle();
    chk("drain_installs", n_bid_inst, DEPTH);
    cycle();

    // Both rejects pending: alternation starting at bid.
    bid_rej = 1'b1; ask_rej = 1'b1; rsp_rdy = 1'b1;
    n_bid_pop = 0; n_ask_pop = 0;
    repeat (4) cycle();
    chk("rr_bid_pops", n_bid_pop, 2);
    chk("rr_ask_pops", n_ask_pop, 2);

    // Ask reject held by back-pressure, then one handshake.
    bid_rej = 1'b0; rsp_rdy = 1'b0;
    base_a = n_ask_pop;
    repeat (5) cycle();
    chk("held_no_pop", n_ask_pop, base_a);
    rsp_rdy = 1'b1;
    cycle();
    chk("held_one_pop", n_ask_pop, base_a + 1);
    ask_rej = 1'b0; rsp_rdy = 1'b0;
    cycle();

    // Reset with five blocked entries and rejects still pending.
    bid_rej = 1'b1; ask_rej = 1'b1;
    repeat (5) send(1'($urandom), rnd_entry());
    cmd_vld = 1'b0;
    do_reset();
    bid_rej = 1'b0; ask_rej = 1'b0;
    base_b = n_bid_inst; base_a = n_ask_inst;
    repeat (4) cycle();
    chk("no_stale_installs", n_bid_inst + n_ask_inst, base_b + base_a);

    // Full FIFO with a simultaneous issue and push attempt, then wrap.
    bid_rej = 1'b1;
    repeat (DEPTH + 1) send(1'b0, rnd_entry());
    bid_rej = 1'b0;
    repeat (12) send(1'($urandom), rnd_entry());
    cmd_vld = 1'b0;
    repeat (DEPTH + 2) cycle();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cmd_vld    = ($urandom_range(0, 3) != 0);
      cmd_is_ask = 1'($urandom);
      cmd_entry  = rnd_entry();
      bid_rej    = ($urandom_range(0, 4) == 0);
      ask_rej    = ($urandom_range(0, 4) == 0);
      rsp_rdy    = 1'($urandom);
      cycle();
    end
    cmd_vld = 1'b0; bid_rej = 1'b0; ask_rej = 1'b0; rsp_rdy = 1'b0;
    repeat (DEPTH + 2) cycle();
    #1 chk("final_occupancy", occupancy_r, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
